// File: rtl/mss_fab_arbiter.sv
`timescale 1ns/1ps
// mss_fab_arbiter: round-robin scheduler that shares the MSS fabric AHB-Lite
// slave port between two single-word REQ/ACK requesters.
module mss_fab_arbiter (
  input  logic        HCLK,
  input  logic        HRESETn,
  // requester 0
  input  logic        REQ0,
  input  logic [31:0] ADDR0,
  input  logic        WRITE0,
  input  logic [1:0]  SIZE0,
  input  logic [31:0] WDATA0,
  output logic        ACK0,
  output logic        ERR0,
  output logic [31:0] RDATA0,
  // requester 1
  input  logic        REQ1,
  input  logic [31:0] ADDR1,
  input  logic        WRITE1,
  input  logic [1:0]  SIZE1,
  input  logic [31:0] WDATA1,
  output logic        ACK1,
  output logic        ERR1,
  output logic [31:0] RDATA1,
  output logic [1:0]  GNT,
  // AHB-Lite master side towards the MSS
  output logic        FABHSEL,
  output logic [1:0]  FABHTRANS,
  output logic [31:0] FABHADDR,
  output logic        FABHWRITE,
  output logic [1:0]  FABHSIZE,
  output logic [31:0] FABHWDATA,
  output logic        FABHMASTLOCK,
  output logic        FABHREADY,
  input  logic [31:0] FABHRDATA,
  input  logic        FABHREADYOUT,
  input  logic        FABHRESP
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_ERRR = 2'd3
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  state_t      state, state_nxt;

  logic        last_grant;
  logic        owner;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        write_q;
  logic [1:0]  size_q;
  logic [1:0]  ack_q;
  logic [1:0]  err_q;
  logic [31:0] rdata0_q;
  logic [31:0] rdata1_q;

  logic        elig0, elig1;
  logic        win_valid;
  logic        winner;
  logic [31:0] win_addr;
  logic [31:0] win_wdata;
  logic        win_write;
  logic [1:0]  win_size;
  logic        win_bad;
  logic        take;
  logic        complete;

  // Arbitration: the ACK of the previous transfer masks its still-high REQ.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    elig0     = REQ0 & ~ack_q[0];
    elig1     = REQ1 & ~ack_q[1];
    win_valid = elig0 | elig1;
    winner    = (elig0 & elig1) ? ~last_grant : elig1;
    win_addr  = winner ? ADDR1  : ADDR0;
    win_wdata = winner ? WDATA1 : WDATA0;
    win_write = winner ? WRITE1 : WRITE0;
    win_size  = winner ? SIZE1  : SIZE0;
    win_bad   = 1'b0;
    case (win_size)
      2'd0:    win_bad = 1'b0;
      2'd1:    win_bad = win_addr[0];
      2'd2:    win_bad = |win_addr[1:0];
      default: win_bad = 1'b1;
    endcase
  end

  assign take     = (state == ST_IDLE) && win_valid;
  assign complete = (state == ST_DATA) && FABHREADYOUT;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (win_valid) state_nxt = win_bad ? ST_ERRR : ST_ADDR;
      ST_ADDR: if (FABHREADYOUT) state_nxt = ST_DATA;
      ST_DATA: if (FABHREADYOUT) state_nxt = ST_IDLE;
      ST_ERRR: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    if (!HRESETn) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Transaction capture; last_grant resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      last_grant <= 1'b1;
      owner      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      write_q    <= 1'b0;
      size_q     <= '0;
    end else if (take) begin
      last_grant <= winner;
      owner      <= winner;
      addr_q     <= win_addr;
      wdata_q    <= win_wdata;
      write_q    <= win_write;
      size_q     <= win_size;
    end
  end

  // ACK/ERR are single-cycle pulses; an illegal request acks in the cycle after sampling.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ack_q    <= '0;
      err_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      ack_q <= '0;
      err_q <= '0;
      if (take && win_bad) begin
        ack_q[winner] <= 1'b1;
        err_q[winner] <= 1'b1;
      end
      if (complete) begin
        ack_q[owner] <= 1'b1;
        err_q[owner] <= FABHRESP;
        if (!write_q) begin
          if (owner) rdata1_q <= FABHRDATA;
          else       rdata0_q <= FABHRDATA;
        end
      end
    end
  end

  assign ACK0   = ack_q[0];
  assign ACK1   = ack_q[1];
  assign ERR0   = err_q[0];
  assign ERR1   = err_q[1];
  assign RDATA0 = rdata0_q;
  assign RDATA1 = rdata1_q;

  // Ownership is visible from the address phase (or error cycle) through the ACK cycle.
  assign GNT = ((state != ST_IDLE) || (|ack_q)) ? (owner ? 2'b10 : 2'b01) : 2'b00;

  assign FABHSEL      = (state == ST_ADDR);
  assign FABHTRANS    = (state == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign FABHADDR     = addr_q;
  assign FABHWRITE    = write_q;
  assign FABHSIZE     = size_q;
  assign FABHWDATA    = wdata_q;
  assign FABHMASTLOCK = 1'b0;
  assign FABHREADY    = FABHREADYOUT;

endmodule

// File: tb/tb_mss_fab_arbiter.sv
`timescale 1ns/1ps
// tb_mss_fab_arbiter: directed self-checking bench for the two-requester
// AHB-Lite fabric arbiter.
module tb_mss_fab_arbiter;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        REQ0, REQ1;
  logic [31:0] ADDR0, ADDR1;
  logic        WRITE0, WRITE1;
  logic [1:0]  SIZE0, SIZE1;
  logic [31:0] WDATA0, WDATA1;
  logic        ACK0, ACK1, ERR0, ERR1;
  logic [31:0] RDATA0, RDATA1;
  logic [1:0]  GNT;
  logic        FABHSEL;
  logic [1:0]  FABHTRANS;
  logic [31:0] FABHADDR;
  logic        FABHWRITE;
  logic [1:0]  FABHSIZE;
  logic [31:0] FABHWDATA;
  logic        FABHMASTLOCK;
  logic        FABHREADY;
  logic [31:0] FABHRDATA;
  logic        FABHREADYOUT;
  logic        FABHRESP;

  int n_checks = 0;
  int n_errors = 0;

  always #5 HCLK = ~HCLK;

  mss_fab_arbiter dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .REQ0(REQ0), .ADDR0(ADDR0), .WRITE0(WRITE0), .SIZE0(SIZE0), .WDATA0(WDATA0),
    .ACK0(ACK0), .ERR0(ERR0), .RDATA0(RDATA0),
    .REQ1(REQ1), .ADDR1(ADDR1), .WRITE1(WRITE1), .SIZE1(SIZE1), .WDATA1(WDATA1),
    .ACK1(ACK1), .ERR1(ERR1), .RDATA1(RDATA1),
    .GNT(GNT),
    .FABHSEL(FABHSEL), .FABHTRANS(FABHTRANS), .FABHADDR(FABHADDR),
    .FABHWRITE(FABHWRITE), .FABHSIZE(FABHSIZE), .FABHWDATA(FABHWDATA),
    .FABHMASTLOCK(FABHMASTLOCK), .FABHREADY(FABHREADY),
    .FABHRDATA(FABHRDATA), .FABHREADYOUT(FABHREADYOUT), .FABHRESP(FABHRESP)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge HCLK);
  endtask

  task automatic pulse_reset();
    HRESETn = 1'b0;
    cyc();
    HRESETn = 1'b1;
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_owner [8] = '{0, 1, 0, 1, 0, 1, 0, 1};
    int n_nonseq, n_ack0, n_ack1, acks;
    logic overlap, pending;

    HRESETn = 1'b0;
    REQ0 = 1'b0; REQ1 = 1'b0;
    ADDR0 = '0; ADDR1 = '0; WRITE0 = 1'b0; WRITE1 = 1'b0;
    SIZE0 = 2'd2; SIZE1 = 2'd2; WDATA0 = '0; WDATA1 = '0;
    FABHRDATA = '0; FABHREADYOUT = 1'b1; FABHRESP = 1'b0;

    // Reset state
    #1;
    check("rst_sel",   32'(FABHSEL), 32'd0);
    check("rst_trans", 32'(FABHTRANS), 32'd0);
    check("rst_addr",  FABHADDR, 32'd0);
    check("rst_gnt",   32'(GNT), 32'd0);
    check("rst_ack",   32'({ACK1, ACK0}), 32'd0);
    check("rst_rdata0", RDATA0, 32'd0);
    check("rst_lock",  32'(FABHMASTLOCK), 32'd0);
    FABHREADYOUT = 1'b0; #1;
    check("hready_follow0", 32'(FABHREADY), 32'd0);
    FABHREADYOUT = 1'b1; #1;
    check("hready_follow1", 32'(FABHREADY), 32'd1);
    cyc();
    HRESETn = 1'b1;
    cyc();

    // Zero-wait write from requester 0
    REQ0 = 1'b1; WRITE0 = 1'b1; ADDR0 = 32'h4000_0010; SIZE0 = 2'd2; WDATA0 = 32'hDEAD_BEEF;
    cyc();
    check("wr_k1_trans", 32'(FABHTRANS), 32'd2);
    check("wr_k1_sel",   32'(FABHSEL), 32'd1);
    check("wr_k1_addr",  FABHADDR, 32'h4000_0010);
    check("wr_k1_write", 32'(FABHWRITE), 32'd1);
    check("wr_k1_size",  32'(FABHSIZE), 32'd2);
    check("wr_k1_gnt",   32'(GNT), 32'd1);
    cyc();
    check("wr_k2_trans", 32'(FABHTRANS), 32'd0);
    check("wr_k2_wdata", FABHWDATA, 32'hDEAD_BEEF);
    check("wr_k2_ack",   32'(ACK0), 32'd0);
    check("wr_k2_gnt",   32'(GNT), 32'd1);
    cyc();
    check("wr_k3_ack", 32'(ACK0), 32'd1);
    check("wr_k3_err", 32'(ERR0), 32'd0);
    check("wr_k3_gnt", 32'(GNT), 32'd1);
    REQ0 = 1'b0;
    cyc();
    check("wr_k4_ack", 32'(ACK0), 32'd0);
    check("wr_k4_gnt", 32'(GNT), 32'd0);

    // Simultaneous reads: strict alternation starting with requester 0
    pulse_reset();
    REQ0 = 1'b1; REQ1 = 1'b1; WRITE0 = 1'b0; WRITE1 = 1'b0;
    ADDR0 = 32'h1000_0000; ADDR1 = 32'h1000_0100; SIZE0 = 2'd2; SIZE1 = 2'd2;
    FABHRDATA = 32'h0BAD_F00D;
    n_nonseq = 0; n_ack0 = 0; n_ack1 = 0; overlap = 1'b0; pending = 1'b0;
    for (int i = 0; i < 100 && (n_ack0 + n_ack1) < 8; i++) begin
      cyc();
      if (FABHTRANS == 2'b10) begin
        if (pending) overlap = 1'b1;
        pending = 1'b1;
        if (n_nonseq < 8)
          check($sformatf("rr_owner%0d", n_nonseq), 32'(GNT),
                (exp_owner[n_nonseq] == 0) ? 32'd1 : 32'd2);
        n_nonseq++;
      end
      if (ACK0 || ACK1) pending = 1'b0;
      if (ACK0) begin n_ack0++; if (n_ack0 == 4) REQ0 = 1'b0; end
      if (ACK1) begin n_ack1++; if (n_ack1 == 4) REQ1 = 1'b0; end
    end
    check("rr_nonseq_count", 32'(n_nonseq), 32'd8);
    check("rr_ack0_count",   32'(n_ack0), 32'd4);
    check("rr_ack1_count",   32'(n_ack1), 32'd4);
    check("rr_no_overlap",   32'(overlap), 32'd0);
    check("rr_rdata0",       RDATA0, 32'h0BAD_F00D);
    check("rr_rdata1",       RDATA1, 32'h0BAD_F00D);
    REQ0 = 1'b0; REQ1 = 1'b0;
    cyc();

    // Wait-stated read from requester 1: three wait states
    REQ1 = 1'b1; WRITE1 = 1'b0; ADDR1 = 32'h2000_0040; SIZE1 = 2'd2;
    FABHRDATA = 32'h1234_5678;
    cyc();
    check("ws_k1_trans", 32'(FABHTRANS), 32'd2);
    check("ws_k1_gnt",   32'(GNT), 32'd2);
    cyc();
    check("ws_k2_sel", 32'(FABHSEL), 32'd0);
    FABHREADYOUT = 1'b0;
    cyc();
    cyc();
    check("ws_k4_ack", 32'(ACK1), 32'd0);
    cyc();
    check("ws_k5_ack", 32'(ACK1), 32'd0);
    FABHREADYOUT = 1'b1;
    cyc();
    check("ws_k6_ack",    32'(ACK1), 32'd1);
    check("ws_k6_err",    32'(ERR1), 32'd0);
    check("ws_k6_rdata1", RDATA1, 32'h1234_5678);
    check("ws_k6_rdata0", RDATA0, 32'h0BAD_F00D);
    REQ1 = 1'b0;
    cyc();

    // AHB ERROR response: wait-state cycle, then error taken
    REQ1 = 1'b1; ADDR1 = 32'h2000_0080;
    cyc();
    cyc();
    FABHREADYOUT = 1'b0; FABHRESP = 1'b1;
    cyc();
    check("er_k3_ack", 32'(ACK1), 32'd0);
    FABHREADYOUT = 1'b1;
    cyc();
    check("er_k4_ack", 32'(ACK1), 32'd1);
    check("er_k4_err", 32'(ERR1), 32'd1);
    REQ1 = 1'b0; FABHRESP = 1'b0;
    cyc();
    check("er_k5_ack",   32'(ACK1), 32'd0);
    check("er_k5_err",   32'(ERR1), 32'd0);
    check("er_k5_gnt",   32'(GNT), 32'd0);
    check("er_k5_trans", 32'(FABHTRANS), 32'd0);

    // Misaligned word, then illegal size
    REQ0 = 1'b1; WRITE0 = 1'b1; ADDR0 = 32'h2000_0002; SIZE0 = 2'd2;
    cyc();
    check("mis_ack", 32'(ACK0), 32'd1);
    check("mis_err", 32'(ERR0), 32'd1);
    check("mis_sel", 32'(FABHSEL), 32'd0);
    REQ0 = 1'b0;
    cyc();
    check("mis_ack_clr", 32'(ACK0), 32'd0);
    check("mis_sel2",    32'(FABHSEL), 32'd0);
    REQ0 = 1'b1; ADDR0 = 32'h2000_0000; SIZE0 = 2'd3;
    cyc();
    check("ill_ack", 32'(ACK0), 32'd1);
    check("ill_err", 32'(ERR0), 32'd1);
    check("ill_sel", 32'(FABHSEL), 32'd0);
    REQ0 = 1'b0;
    cyc();
    check("ill_sel2", 32'(FABHSEL), 32'd0);

    // Reset during a data-phase wait state
    REQ0 = 1'b1; WRITE0 = 1'b0; ADDR0 = 32'h3000_0000; SIZE0 = 2'd2;
    cyc();
    cyc();
    FABHREADYOUT = 1'b0;
    cyc();
    #1 HRESETn = 1'b0;
    #1;
    check("mr_sel",    32'(FABHSEL), 32'd0);
    check("mr_trans",  32'(FABHTRANS), 32'd0);
    check("mr_addr",   FABHADDR, 32'd0);
    check("mr_size",   32'(FABHSIZE), 32'd0);
    check("mr_gnt",    32'(GNT), 32'd0);
    check("mr_rdata0", RDATA0, 32'd0);
    REQ0 = 1'b0; FABHREADYOUT = 1'b1;
    cyc();
    HRESETn = 1'b1;
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (ACK0 || ACK1) acks++;
    end
    check("mr_no_ack", 32'(acks), 32'd0);

    // After reset: tie goes to requester 0, then requester 1
    REQ0 = 1'b1; REQ1 = 1'b1; WRITE0 = 1'b1; WRITE1 = 1'b1;
    ADDR0 = 32'h3000_0004; WDATA0 = 32'h55AA_55AA; SIZE0 = 2'd2;
    ADDR1 = 32'h3000_0008; WDATA1 = 32'h0F0F_0F0F; SIZE1 = 2'd2;
    cyc();
    check("pr_k1_gnt",  32'(GNT), 32'd1);
    check("pr_k1_addr", FABHADDR, 32'h3000_0004);
    cyc();
    check("pr_k2_wdata", FABHWDATA, 32'h55AA_55AA);
    check("pr_k2_ack",   32'(ACK0), 32'd0);
    cyc();
    check("pr_k3_ack", 32'(ACK0), 32'd1);
    check("pr_k3_err", 32'(ERR0), 32'd0);
    REQ0 = 1'b0;
    cyc();
    check("pr1_addr", FABHADDR, 32'h3000_0008);
    check("pr1_gnt",  32'(GNT), 32'd2);
    cyc();
    check("pr1_wdata", FABHWDATA, 32'h0F0F_0F0F);
    cyc();
    check("pr1_ack", 32'(ACK1), 32'd1);
    REQ1 = 1'b0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
